// File: rtl/priority_arbiter_pkg.sv
// Shared types and constants for the priority arbiter and its pick logic.
package priority_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int MIN_N = 2;
  localparam int MAX_N = 32;

endpackage

// File: rtl/priority_arbiter_prio_pick.sv
// Combinational first-set picker: rotate by base, find first set, un-rotate.
module prio_pick
  import priority_arbiter_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] base,
  input  logic             mode,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] eff_base;
  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] first;
  logic [IDX_W:0]   sum;

  always_comb begin
    eff_base = (mode == MODE_RR) ? base : '0;
    dbl      = {vec, vec} >> eff_base;
    // Low N bits of the doubled vector shifted by base give rot[i] = vec[(i+base) mod N].
    rot      = dbl[N-1:0];
    first    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) first = IDX_W'(i);
    end
    found = |rot;
    sum   = {1'b0, first} + {1'b0, eff_base};
    if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/priority_arbiter.sv
// Registered N-input arbiter: sticky pending vector, fixed or round-robin pick,
// grant presented as index plus one-hot behind a valid/ready handshake.
//
// state | meaning
// IDLE  | no grant presented; load a selection as soon as cand is non-zero
// GRANT | grant presented and held until accepted; chain the next pick on accept
module priority_arbiter
  import priority_arbiter_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N),
  parameter int RR_EN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N-1:0]     grant_onehot,
  input  logic             grant_ready,
  output logic [N-1:0]     pending
);

  localparam logic PICK_MODE = (RR_EN != 0) ? MODE_RR : MODE_FIXED;

  state_e           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt, ptr_adv, sel_base;
  logic [N-1:0]     held, cand, clr, pending_nxt, pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found, accept, load;

  assign accept      = (state == GRANT) && grant_ready;
  assign held        = (state == GRANT) ? grant_onehot : '0;
  assign cand        = (pending | req) & mask & ~held;
  assign clr         = accept ? grant_onehot : '0;
  assign pending_nxt = (pending & ~clr) | req;
  // Pointer wraps at N, not at 2^IDX_W, so non power-of-two sizes rotate correctly.
  assign ptr_adv     = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
  assign sel_base    = accept ? ptr_adv : ptr;

  prio_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .vec   (cand),
    .base  (sel_base),
    .mode  (PICK_MODE),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          load      = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          ptr_nxt = ptr_adv;
          if (pick_found) load = 1'b1;
          else            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      pending      <= '0;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      grant_onehot <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      pending     <= pending_nxt;
      grant_valid <= (state_nxt == GRANT);
      if (load) begin
        grant_idx    <= pick_idx;
        grant_onehot <= pick_onehot;
      end else if (state_nxt == IDLE) begin
        grant_onehot <= '0;
      end
    end
  end

endmodule
